// File: rtl/dmem_bridge.sv
// Bridges single-cycle MEM-stage loads/stores onto a req/ack data bus with
// MIPS32 lane steering, extension and alignment checks. Optional bus timeout: DMEM_TIMEOUT_EN.
module dmem_bridge #(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  input  logic [1:0]   size,
  input  logic         sign_ext,
  output logic         stall,
  output logic         misalign,
  output logic         bus_req,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [3:0]   bus_be,
  output logic [W-1:0] bus_wdata,
  input  logic [W-1:0] bus_rdata,
  input  logic         bus_ack,
  output logic         bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state_q, state_d;

  logic         bus_req_q, bus_we_q, misalign_q, bus_err_q, both_q, sext_q;
  logic [W-1:0] bus_addr_q, bus_wdata_q, l_data_q;
  logic [3:0]   bus_be_q;
  logic [1:0]   off_q, size_q;

  // Request decode from the MEM-stage inputs; a simultaneous load+store is a store.
  logic         req, is_byte, is_half, misal;
  logic [W-1:0] addr, wdata_c, shifted, load_val;
  logic [3:0]   be_c;
  logic         timeout_hit;

  assign req     = load_en | store_en;
  assign addr    = store_en ? s_addr : l_addr;
  assign is_byte = (size == 2'b00);
  assign is_half = (size == 2'b01);
  assign misal   = (is_half & addr[0]) | (!is_byte && !is_half && (addr[1:0] != 2'b00));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    be_c    = 4'b1111;
    wdata_c = s_data;
    if (is_byte) begin
      be_c    = 4'b0001 << addr[1:0];
      wdata_c = {4{s_data[7:0]}};
    end else if (is_half) begin
      be_c    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{s_data[15:0]}};
    end
  end

  // Aligned halves have off_q[0]=0, so one shift serves byte and half lanes.
  assign shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = bus_rdata;
    if (size_q == 2'b00)
      load_val = {{(W-8){sext_q & shifted[7]}}, shifted[7:0]};
    else if (size_q == 2'b01)
      load_val = {{(W-16){sext_q & shifted[15]}}, shifted[15:0]};
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Counter value k-1 in the k-th BUSY cycle; an ack in that cycle still wins.
  assign timeout_hit = !bus_ack && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q == IDLE)
      cnt_q <= '0;
    else if (state_q == BUSY && !bus_ack)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT;
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req && !misal) state_d = BUSY;
      BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      IDLE:    stall = req && !misal;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Bus and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      l_data_q    <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      both_q      <= 1'b0;
      sext_q      <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req && misal) begin
            misalign_q <= 1'b1;
            l_data_q   <= '0;
          end else if (req) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= store_en;
            bus_addr_q  <= {addr[W-1:2], 2'b00};
            bus_be_q    <= be_c;
            bus_wdata_q <= wdata_c;
            both_q      <= load_en & store_en;
            sext_q      <= sign_ext;
            off_q       <= addr[1:0];
            size_q      <= size;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q)   l_data_q <= load_val;
            else if (both_q) l_data_q <= '0;
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            l_data_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign l_data    = l_data_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the MEM stage's CPU memory interface: consumes load_en/l_addr, store_en/s_addr/s_data and returns l_data.
- Converts single-cycle MEM-stage requests into a req/ack handshake on the data bus.
- Performs MIPS32 byte/half/word lane steering, sign extension and alignment checking.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
W, 32, data/address width (WORD_WIDTH); lane logic fixed for 32
TIMEOUT, 16, max cycles waiting for bus_ack (used only with DMEM_TIMEOUT_EN)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
load_en  input  1  load request from MEM stage
l_addr  input  W  load byte address
l_data  output  W  lane-steered, extended load result
store_en  input  1  store request from MEM stage
s_addr  input  W  store byte address
s_data  input  W  store data, right-justified
size  input  2  00 byte, 01 half, 10 word; 11 treated as word
sign_ext  input  1  1: sign-extend byte/half loads; 0: zero-extend
stall  output  1  1 = hold pipeline, MEM inputs must stay stable
misalign  output  1  one-cycle pulse: misaligned access rejected
bus_req  output  1  bus request
bus_we  output  1  1 store, 0 load
bus_addr  output  W  word-aligned address {addr[W-1:2],2'b00}
bus_be  output  4  byte enables, little-endian lanes
bus_wdata  output  W  store data replicated into the enabled lanes
bus_rdata  input  W  read data, valid when bus_ack=1
bus_ack  input  1  transaction complete
bus_err  output  1  one-cycle pulse on timeout (optional feature only)

Behaviour:
- Reset (synchronous, active-high): state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, l_data, misalign and bus_err all 0.
- Reset mid-transaction: the transaction is dropped, bus_req goes 0 next edge, and no l_data update occurs.
- Request: req = load_en | store_en. If both are 1, it is a store and l_data = 0.
- Alignment:
  - half with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
  - A misaligned request in IDLE raises misalign for 1 cycle, l_data = 0, no bus cycle, and stall = 0 (combinational).
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an aligned request, stall = 1 combinationally in the same cycle.
  - Next edge latches bus_addr/bus_be/bus_wdata/bus_we, sets bus_req = 1, and goes to BUSY.
  - Otherwise stall = 0.
- BUSY:
  - stall = 1.
  - bus_req and all bus outputs are held stable until bus_ack = 1 is sampled.
  - On the ack edge: bus_req = 0; for loads, l_data is registered from bus_rdata (steered and extended); go to DONE.
- DONE:
  - stall = 0 for exactly one cycle; the pipeline advances.
  - The still-present request is NOT reissued.
  - Next edge returns to IDLE.
  - l_data holds its value until the next completed load.
- Lanes:
  - byte: be = 1 << addr[1:0]; wdata = {4{s_data[7:0]}}.
  - half: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = {2{s_data[15:0]}}.
  - word: be = 1111; wdata = s_data.
- Load extraction: selects the lane from addr[1:0] and extends to W per sign_ext. Word loads ignore sign_ext.
- bus_ack while bus_req = 0 is ignored.
- Minimum aligned latency: request cycle + 1 BUSY cycle (ack in first BUSY cycle) + DONE, i.e. stall high for 2 cycles.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the transaction is aborted: bus_req = 0, bus_err pulses 1 cycle, l_data = 0, and the FSM goes to DONE (pipeline released).
  - An ack in the same cycle as the counter reaching TIMEOUT wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely; bus_err is tied 0.

Test Plan:
- Word load 0x0000_1004, bus_ack after 3 BUSY cycles, rdata 0xDEAD_BEEF -> bus_addr 0x1004, be 1111, stall high 4 cycles, l_data 0xDEADBEEF in DONE.
- Signed byte load addr 0x1003, rdata 0x80xx_xxxx -> be 1000, l_data 0xFFFF_FF80; repeat with sign_ext=0 -> 0x0000_0080.
- Half store addr 0x2002, s_data 0x1234_ABCD -> bus_we 1, be 1100, wdata 0xABCD_ABCD, stall drops after ack, no second bus_req while inputs are held in DONE.
- Word load addr 0x3001 -> misalign pulse 1 cycle, bus_req stays 0, stall 0, l_data 0.
- rst asserted in BUSY -> next edge bus_req 0, state IDLE, l_data 0; a subsequent load completes normally.
- DMEM_TIMEOUT_EN, TIMEOUT=16, no ack -> bus_err pulse after 16 BUSY cycles, stall released in DONE; ack on cycle 16 -> normal completion, bus_err 0.
